// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES encryption round sequencer for an external round datapath
//
// Accepts one plaintext block, applies the initial AddRoundKey with rk0, then
// issues ROUNDS passes through an external round datapath and returns the
// ciphertext on a valid/ready port.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data   plaintext input handshake (byte 0 in [127:120])
//   rk0                         round key 0, sampled only on the accept edge
//   dp_valid_in/dp_data_in      one-cycle issue strobe and state to the datapath
//   dp_round/dp_last            round-key index and MixColumns-bypass flag
//   dp_valid_out/dp_data_out    datapath result
//   out_valid/out_ready/out_data ciphertext output handshake
//   busy                        high whenever not idle
//   err_timeout/err_spurious    sticky error flags, cleared only by reset

module aes_round_ctrl #(
  parameter int DATA_W  = 128,
  parameter int ROUNDS  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] rk0,
  output logic              dp_valid_in,
  output logic [DATA_W-1:0] dp_data_in,
  output logic [3:0]        dp_round,
  output logic              dp_last,
  input  logic              dp_valid_out,
  input  logic [DATA_W-1:0] dp_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_spurious
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] blk_q, blk_d;
  logic [3:0]        round_q, round_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              err_to_q, err_to_d;
  logic              err_sp_q, err_sp_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      round_q    <= '0;
      wait_cnt_q <= '0;
      err_to_q   <= 1'b0;
      err_sp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      round_q    <= round_d;
      wait_cnt_q <= wait_cnt_d;
      err_to_q   <= err_to_d;
      err_sp_q   <= err_sp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    round_d    = round_q;
    wait_cnt_d = wait_cnt_q;
    err_to_d   = err_to_q;
    err_sp_d   = err_sp_q;

    case (state_q)
      S_IDLE: begin
        if (dp_valid_out) err_sp_d = 1'b1;
        if (in_valid) begin
          // Initial AddRoundKey is done here; the datapath only sees rounds 1..ROUNDS.
          blk_d   = in_data ^ rk0;
          round_d = 4'd1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (dp_valid_out) err_sp_d = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
        // A result on the expiry cycle takes priority over the timeout.
        if (dp_valid_out) begin
          blk_d = dp_data_out;
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_ISSUE;
          end
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          err_to_d = 1'b1;
          round_d  = '0;
          state_d  = S_IDLE;
        end
      end

      S_DONE: begin
        if (dp_valid_out) err_sp_d = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign dp_valid_in  = (state_q == S_ISSUE);
  assign out_valid    = (state_q == S_DONE);
  assign dp_data_in   = blk_q;
  assign out_data     = blk_q;
  assign dp_round     = round_q;
  assign dp_last      = (state_q == S_ISSUE) && (round_q == LAST_ROUND);
  assign err_timeout  = err_to_q;
  assign err_spurious = err_sp_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl with an AES-128 datapath model
module tb_aes_round_ctrl;

  localparam int ROUNDS  = 10;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] rk0;
  logic         dp_valid_in;
  logic [127:0] dp_data_in;
  logic [3:0]   dp_round;
  logic         dp_last;
  logic         dp_valid_out;
  logic [127:0] dp_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         err_timeout;
  logic         err_spurious;

  aes_round_ctrl #(.DATA_W(128), .ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .rk0(rk0),
    .dp_valid_in(dp_valid_in), .dp_data_in(dp_data_in), .dp_round(dp_round), .dp_last(dp_last),
    .dp_valid_out(dp_valid_out), .dp_data_out(dp_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Datapath model state: per-round latency (0 = never answer), one pending result.
  int                  lat_of[0:15];
  logic [0:10][127:0]  rkeys;
  bit                  pend = 0;
  int                  pend_cnt = 0;
  logic [127:0]        pend_data;
  bit                  spur_now = 0;
  int                  issue_cyc = 0;
  logic [3:0]          issue_round = '0;
  logic [3:0]          rnd_log[$];
  logic                last_log[$];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           lat;
    int           bp;
  } vec_t;
  vec_t tbl[3];

  // ---------------- AES-128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] s = a;
    logic [7:0] r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gm(s, s);
      r = gm(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k, input logic last);
    logic [7:0] b[16];
    logic [7:0] t[16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sb(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [0:10][127:0] key_expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    logic [0:10][127:0] ks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [0:10][127:0] ks = key_expand(key);
    logic [127:0] s = pt ^ ks[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, ks[r], r == 10);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- bench plumbing ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic dp_model();
    int idx;
    logic [127:0] k;
    dp_valid_out = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        dp_valid_out = 1'b1;
        dp_data_out  = pend_data;
        pend         = 0;
      end
    end
    if (spur_now) begin
      dp_valid_out = 1'b1;
      dp_data_out  = rnd128();
      spur_now     = 0;
    end
    if (dp_valid_in) begin
      rnd_log.push_back(dp_round);
      last_log.push_back(dp_last);
      issue_cyc   = cyc;
      issue_round = dp_round;
      idx = int'(dp_round);
      k = (idx <= 10) ? rkeys[idx] : '0;
      if (lat_of[idx] > 0) begin
        pend      = 1;
        pend_cnt  = lat_of[idx];
        pend_data = aes_round(dp_data_in, k, dp_last);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    dp_model();
  endtask

  task automatic set_lat(input int l);
    for (int r = 0; r < 16; r++) lat_of[r] = l;
  endtask

  task automatic check_reset_vals();
    chk("rst_ctrl", {in_ready, busy, out_valid, dp_valid_in, dp_last, err_timeout, err_spurious}, 7'b1000000);
    chk("rst_round", dp_round, 4'd0);
    chk("rst_out_data", out_data, '0);
    chk("rst_dp_data_in", dp_data_in, '0);
  endtask

  task automatic do_accept(input logic [127:0] pt, input logic [127:0] key, output int acc);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("accept_wait", in_ready, 1'b1);
    rkeys = key_expand(key);
    rnd_log.delete();
    last_log.delete();
    in_valid = 1'b1;
    in_data  = pt;
    rk0      = key;
    step();
    acc      = cyc;
    in_valid = 1'b0;
    in_data  = rnd128();
    rk0      = rnd128();
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 400) begin
      step();
      n++;
    end
    chk("out_wait", out_valid, 1'b1);
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int bp,
                           output logic [127:0] ct);
    int acc;
    int exp_lat = 0;
    for (int r = 1; r <= ROUNDS; r++) exp_lat += lat_of[r] + 1;
    out_ready = (bp == 0);
    do_accept(pt, key, acc);
    wait_out();
    ct = out_data;
    if (out_valid) begin
      chk("latency", cyc - acc, exp_lat);
      chk("ciphertext", out_data, ref_encrypt(pt, key));
      for (int k = 1; k < bp; k++) begin
        step();
        chk("bp_hold", {out_valid, busy, in_ready}, 3'b110);
        chk("bp_data", out_data, ct);
      end
      out_ready = 1'b1;
      step();
      chk("after_handshake", {in_ready, out_valid, busy}, 3'b100);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] ct, ct2, pt, key;
    int acc, n;
    bit saw_out;

    in_valid = 1'b0; in_data = '0; rk0 = '0;
    dp_valid_out = 1'b0; dp_data_out = '0; out_ready = 1'b0;
    set_lat(1);

    tbl[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 0};
    tbl[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32, 2, 0};
    tbl[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 3, 2};

    // Reset with a handshake offered: it must be ignored.
    reset = 1'b1;
    in_valid = 1'b1; in_data = rnd128(); rk0 = rnd128();
    step();
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    check_reset_vals();

    // Known-answer vectors, including the FIPS-197 one with L=1 (20 cycles).
    for (int i = 0; i < 3; i++) begin
      set_lat(tbl[i].lat);
      run_block(tbl[i].pt, tbl[i].key, tbl[i].bp, ct);
      chk("table_ct", ct, tbl[i].ct);
      chk("round_count", rnd_log.size(), ROUNDS);
      for (int r = 0; r < ROUNDS && r < rnd_log.size(); r++)
        chk("round_seq", {last_log[r], rnd_log[r]}, {1'(r == ROUNDS - 1), 4'(r + 1)});
    end

    // Random blocks with random per-round latency up to and including the expiry cycle.
    for (int i = 0; i < 8; i++) begin
      for (int r = 1; r <= ROUNDS; r++) lat_of[r] = $urandom_range(1, TIMEOUT);
      run_block(rnd128(), rnd128(), $urandom_range(0, 3), ct);
    end
    chk("no_errors_yet", {err_timeout, err_spurious}, 2'b00);

    // Backpressure for 7 DONE cycles, then a back-to-back block.
    set_lat(1);
    run_block(rnd128(), rnd128(), 7, ct);
    run_block(rnd128(), rnd128(), 0, ct);

    // Timeout tie: round 2 answers exactly on the expiry cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals();
    set_lat(1);
    lat_of[2] = TIMEOUT;
    run_block(rnd128(), rnd128(), 0, ct);
    chk("tie_no_timeout", err_timeout, 1'b0);

    // Timeout: round 3 never answers.
    set_lat(1);
    lat_of[3] = 0;
    out_ready = 1'b1;
    do_accept(rnd128(), rnd128(), acc);
    saw_out = 0;
    n = 0;
    while (!err_timeout && n < 200) begin
      step();
      n++;
      if (out_valid) saw_out = 1;
    end
    chk("timeout_flag", err_timeout, 1'b1);
    chk("timeout_round", issue_round, 4'd3);
    // Edges from the one that samples the round-3 issue to the one that sets the flag.
    chk("timeout_delay", cyc - issue_cyc - 1, TIMEOUT);
    chk("timeout_idle", {in_ready, busy, saw_out}, 3'b100);
    set_lat(1);
    run_block(rnd128(), rnd128(), 0, ct);
    chk("timeout_sticky", err_timeout, 1'b1);

    // Spurious result during DONE, then during IDLE.
    chk("spur_clear", err_spurious, 1'b0);
    pt = rnd128();
    key = rnd128();
    out_ready = 1'b0;
    do_accept(pt, key, acc);
    wait_out();
    ct = out_data;
    spur_now = 1;
    step();
    step();
    chk("spur_done_flag", err_spurious, 1'b1);
    chk("spur_done_hold", {out_valid, busy}, 2'b11);
    chk("spur_done_data", out_data, ref_encrypt(pt, key));
    out_ready = 1'b1;
    step();
    chk("spur_done_release", in_ready, 1'b1);
    spur_now = 1;
    step();
    step();
    chk("spur_idle_state", {in_ready, busy, out_valid}, 3'b100);
    chk("spur_idle_data", out_data, ct);

    // Reset during round-5 WAIT; the round-5 result arrives late, after reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_lat(1);
    lat_of[5] = 3;
    do_accept(rnd128(), rnd128(), acc);
    n = 0;
    while (!(dp_valid_in && dp_round == 4'd5) && n < 100) begin
      step();
      n++;
    end
    chk("reach_round5", {dp_valid_in, dp_round}, {1'b1, 4'd5});
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals();
    step();
    chk("late_not_yet", err_spurious, 1'b0);
    step();
    chk("late_spurious", err_spurious, 1'b1);
    chk("late_ignored", {out_data, in_ready}, {128'h0, 1'b1});
    set_lat(1);
    run_block(rnd128(), rnd128(), 0, ct2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES encryption round sequencer. It accepts one 128-bit plaintext block per transaction and applies the initial AddRoundKey locally. It then issues ROUNDS passes through an external round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) and returns the ciphertext over a valid/ready output port. It owns the round counter, the last-round MixColumns bypass control, the round-key index, and timeout/spurious-response error detection for the datapath.

Parameters:
DATA_W, 128, block width; fixed at 128.
ROUNDS, 10, number of datapath passes (10/12/14 for AES-128/192/256); legal range 1..14.
TIMEOUT, 15, maximum cycles spent in WAIT before abort; legal range 1..255.

Ports:
clk  in  1  clock; all logic rising-edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  plaintext block offered.
in_ready  out  1  controller can accept a block.
in_data  in  128  plaintext, byte 0 in [127:120].
rk0  in  128  round key 0; sampled only on the accept edge.
dp_valid_in  out  1  one-cycle issue strobe to the datapath.
dp_data_in  out  128  state presented to the datapath.
dp_round  out  4  round-key index for this pass (1..ROUNDS).
dp_last  out  1  final pass; the datapath must bypass MixColumns.
dp_valid_out  in  1  datapath result valid.
dp_data_out  in  128  datapath result.
out_valid  out  1  ciphertext valid.
out_ready  in  1  consumer accepts the ciphertext.
out_data  out  128  ciphertext.
busy  out  1  high in every state except IDLE.
err_timeout  out  1  sticky; a block was aborted by timeout.
err_spurious  out  1  sticky; dp_valid_out was seen outside WAIT.

Behaviour:
- Synchronous, active-high reset. While reset=1 at an edge, the following take effect at that edge:
  - state=IDLE, state_reg=0, round=0, wait_cnt=0;
  - err_timeout=0, err_spurious=0.
- Resulting outputs:
  - in_ready=1, busy=0, out_valid=0, dp_valid_in=0;
  - dp_round=0, dp_last=0, out_data=0, dp_data_in=0.
- Handshakes and decodes presented while reset=1 are ignored.
- Output decodes from registered state:
  - in_ready = (state==IDLE); busy = !in_ready;
  - dp_valid_in = (state==ISSUE); out_valid = (state==DONE);
  - dp_data_in = out_data = state_reg; dp_round = round;
  - dp_last = (state==ISSUE && round==ROUNDS).
- IDLE: on the edge where in_valid && in_ready, load state_reg <= in_data ^ rk0 and round <= 1, then go to ISSUE. Without in_valid, remain in IDLE.
- ISSUE: lasts exactly one cycle; dp_valid_in=1. Clear wait_cnt and go to WAIT.
- WAIT: each edge, wait_cnt increments (saturating at 255).
  - On dp_valid_out=1: state_reg <= dp_data_out.
    - If round==ROUNDS, go to DONE.
    - Otherwise round <= round+1 and go to ISSUE.
  - Else if wait_cnt==TIMEOUT-1: set err_timeout, discard the block, round <= 0, go to IDLE. out_valid is never raised for the aborted block.
  - dp_valid_out=1 on the same edge the timeout would fire: the valid result wins and no error is raised.
- DONE: out_valid=1. out_data stays stable until out_valid && out_ready, then go to IDLE.
  - in_ready rises the cycle after the output handshake; there is no same-cycle turnaround.
  - out_ready held high on DONE entry: the handshake completes on the first DONE cycle.
- Spurious result: dp_valid_out=1 in IDLE, ISSUE or DONE sets err_spurious. The data is ignored and state_reg is unchanged.
- Latency: with datapath latency L (dp_valid_out L cycles after dp_valid_in), each round costs L+1 cycles.
  - out_valid rises ROUNDS*(L+1) cycles after the accept edge.
  - MixColumns-style datapath, L=1, ROUNDS=10: 20 cycles.
- Reset mid-operation (any state): the in-flight block is dropped and outputs return to their reset values on the next edge. A late dp_valid_out arriving after reset, while IDLE, sets err_spurious.
- Error flags clear only by reset. They do not block new transactions.

Test Plan:
- FIPS-197 vector. Stimulus: in_data=00112233445566778899aabbccddeeff, rk0=000102030405060708090a0b0c0d0e0f, bench datapath model with L=1. Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises 20 cycles after accept; dp_round sequence is 1..10; dp_last high only on round 10.
- Backpressure. Stimulus: out_ready held low 7 cycles in DONE. Required: out_valid and out_data stable for 7 cycles, busy=1; in_ready=1 one cycle after out_ready rises; a back-to-back second block completes correctly.
- Timeout. Stimulus: datapath withholds dp_valid_out on round 3. Required: err_timeout=1 exactly TIMEOUT=15 cycles after the round-3 dp_valid_in; state returns to IDLE; out_valid never asserted; next block encrypts correctly with err_timeout still 1.
- Timeout tie. Stimulus: dp_valid_out arrives on the exact expiry cycle. Required: round advances and err_timeout stays 0.
- Spurious result. Stimulus: dp_valid_out pulsed while IDLE and again during DONE. Required: err_spurious=1; out_data unchanged; state unaffected.
- Reset mid-round. Stimulus: reset pulsed one cycle during round 5 WAIT, followed by a late dp_valid_out. Required: all outputs at reset values next cycle; err_spurious=1 from the late result; the next block yields correct ciphertext.
